water_sensor_conditioner: RTL
=============================

// Module: water_sensor_conditioner
// PURPOSE
//  Upstream front end for the parking-lot water-level FSM. Takes the two raw float
//  switches (10 mm, 20 mm), synchronises and debounces them, and checks that the pair
//  is physically plausible (20 mm cannot be wet while 10 mm is dry). It drives clean
//  w10mm/w20mm to the level FSM, plus a latched sensor fault for the operator panel.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive stable cycles required before a filtered level changes
//  CNT_W            5   width of debounce and warm-up counters (2**CNT_W > DEBOUNCE_CYCLES+2)
//  FAULT_CYCLES     8   cycles an implausible filtered pair may persist before fault latches
// PORTS
//  clk          in   1  system clock; single clock domain
//  reset        in   1  synchronous, active-high reset
//  raw_10mm     in   1  raw 10 mm switch, asynchronous, may bounce
//  raw_20mm     in   1  raw 20 mm switch, asynchronous, may bounce
//  fault_clear  in   1  single-cycle operator request to leave FAULT
//  w10mm        out  1  conditioned 10 mm level to the level FSM
//  w20mm        out  1  conditioned 20 mm level to the level FSM
//  fault        out  1  latched sensor-plausibility fault
//  level_valid  out  1  1 = w10mm/w20mm are trustworthy
// BEHAVIOUR
//  - Reset: sync flops, filtered levels, and all counters go to 0. State = OK.
//    w10mm = w20mm = fault = level_valid = 0. This applies on any cycle, including mid-FAULT.
//  - Sync: 2-flop synchroniser per channel, 2 cycles latency.
//  - Debounce, per channel, counter cnt:
//    - synced == filt: cnt <= 0.
//    - synced != filt and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//    - synced != filt and cnt == DEBOUNCE_CYCLES-1: filt <= synced, cnt <= 0.
//    - Net latency from a clean raw edge to a filt change is 2+DEBOUNCE_CYCLES cycles.
//    - A raw pulse shorter than DEBOUNCE_CYCLES never reaches filt.
//  - Plausibility FSM. imp = filt20 & ~filt10.
//    - OK: outputs = (filt10, filt20); the pair is also stored as last_good.
//      If imp: go to SUSPECT and set fcnt <= 0.
//    - SUSPECT: outputs hold last_good; fcnt increments each cycle.
//      - ~imp: return to OK (outputs follow filt again on the next cycle).
//      - imp and fcnt == FAULT_CYCLES-1: go to FAULT.
//      - fault_clear has no effect in this state.
//    - FAULT: fault = 1; fail-safe outputs w10mm = w20mm = 1, so downstream treats it as high water.
//      - Exit to OK only when fault_clear = 1 and ~imp in the same cycle.
//      - fault_clear while imp is ignored; fault stays latched.
//  - Simultaneous events:
//    - Both channels may flip on the same edge; the resulting pair is evaluated the same cycle.
//    - imp rising exactly when fcnt would expire is not a special case; only the current imp matters.
//  - level_valid:
//    - A warm-up counter counts from 0 after reset and saturates at DEBOUNCE_CYCLES+2.
//    - level_valid = (warm-up saturated) & (state != FAULT).
//    - It is 1 in SUSPECT, since the held values are the last plausible pair.
//  - All outputs are registered; no combinational path from raw_* or fault_clear to outputs.
// TESTING  (DEBOUNCE_CYCLES=4, FAULT_CYCLES=3)
//  1 Release reset, raws = 0 -> level_valid 0 for 5 edges, 1 from the 6th edge; outputs 0,0; fault 0.
//  2 raw_10mm 0->1 held -> w10mm rises exactly 6 cycles after the edge.
//    A 3-cycle raw pulse -> w10mm stays 0. Bounce 1-0-1 resets the count.
//  3 raw_10mm = 1 settled, then raw_20mm 0->1 -> w20mm rises 6 cycles later; outputs 1,1; fault 0.
//  4 raw_20mm = 1 with raw_10mm = 0 -> once filt20 = 1: outputs hold 0,0 for 3 cycles, then
//    fault = 1, outputs 1,1, level_valid 0. fault_clear while imp -> still FAULT.
//    Drop raw_20mm, wait 6 cycles, pulse fault_clear -> next cycle OK, fault 0, outputs 0,0.
//  5 Implausible pair lasting 2 cycles (filt10 lags filt20) -> SUSPECT then OK; fault never sets.
//  6 Assert reset for 1 cycle while in FAULT -> next cycle all outputs 0; warm-up restarts
//    (level_valid 1 again 6 edges after release).

Source files
------------

// File: rtl/water_sensor_conditioner_if.sv
// Float-switch sensor bundle: raw inputs, operator clear, conditioned outputs.
// master drives the raw side, slave is the conditioner.
interface water_sensor_conditioner_if;
  logic raw_10mm;
  logic raw_20mm;
  logic fault_clear;
  logic w10mm;
  logic w20mm;
  logic fault;
  logic level_valid;

  modport master (
    output raw_10mm,
    output raw_20mm,
    output fault_clear,
    input  w10mm,
    input  w20mm,
    input  fault,
    input  level_valid
  );

  modport slave (
    input  raw_10mm,
    input  raw_20mm,
    input  fault_clear,
    output w10mm,
    output w20mm,
    output fault,
    output level_valid
  );
endinterface

// File: rtl/water_sensor_conditioner.sv
// Water float-switch front end: sync, debounce, plausibility check and
// latched fault with fail-safe high-water outputs.
module water_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5,
  parameter int FAULT_CYCLES    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  water_sensor_conditioner_if.slave  bus
);

  localparam int FW = $clog2(FAULT_CYCLES + 1);

  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WU_SAT =
    CNT_W'(DEBOUNCE_CYCLES + 2);
  localparam logic [FW-1:0] FC_LAST =
    FW'(FAULT_CYCLES - 1);

  localparam logic [1:0] S_OK  = 2'd0;
  localparam logic [1:0] S_SUS = 2'd1;
  localparam logic [1:0] S_FLT = 2'd2;

  logic [1:0]            s1;
  logic [1:0]            s2;
  logic [1:0]            filt;
  logic [1:0]            filt_n;
  logic [1:0][CNT_W-1:0] cnt;
  logic [1:0][CNT_W-1:0] cnt_n;
  logic [1:0]            state;
  logic [1:0]            state_n;
  logic [FW-1:0]         fcnt;
  logic [FW-1:0]         fcnt_n;
  logic [CNT_W-1:0]      wcnt;
  logic [CNT_W-1:0]      wcnt_n;
  logic                  imp_n;

  // Bit 0 is the 10 mm channel, bit 1 the 20 mm channel.
  always_comb begin
    filt_n = filt;
    cnt_n  = cnt;
    for (int i = 0; i < 2; i++) begin
      if (s2[i] == filt[i]) begin
        cnt_n[i] = '0;
      end else if (cnt[i] == DB_LAST) begin
        filt_n[i] = s2[i];
        cnt_n[i]  = '0;
      end else begin
        cnt_n[i] = cnt[i] + 1'b1;
      end
    end
  end

  // The FSM judges the pair being loaded this edge, so the
  // registered outputs never show an implausible pair.
  assign imp_n = filt_n[1] & ~filt_n[0];

  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    unique case (state)
      S_OK: begin
        if (imp_n) begin
          state_n = S_SUS;
          fcnt_n  = '0;
        end
      end
      S_SUS: begin
        if (!imp_n) begin
          state_n = S_OK;
        end else if (fcnt == FC_LAST) begin
          state_n = S_FLT;
        end else begin
          fcnt_n = fcnt + 1'b1;
        end
      end
      S_FLT: begin
        if (bus.fault_clear && !imp_n) begin
          state_n = S_OK;
        end
      end
      default: begin
        state_n = S_OK;
      end
    endcase
  end

  assign wcnt_n = (wcnt == WU_SAT) ? wcnt
                                   : wcnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1              <= '0;
      s2              <= '0;
      filt            <= '0;
      cnt             <= '0;
      state           <= S_OK;
      fcnt            <= '0;
      wcnt            <= '0;
      bus.w10mm       <= 1'b0;
      bus.w20mm       <= 1'b0;
      bus.fault       <= 1'b0;
      bus.level_valid <= 1'b0;
    end else begin
      s1    <= {bus.raw_20mm, bus.raw_10mm};
      s2    <= s1;
      filt  <= filt_n;
      cnt   <= cnt_n;
      state <= state_n;
      fcnt  <= fcnt_n;
      wcnt  <= wcnt_n;
      bus.fault       <= (state_n == S_FLT);
      bus.level_valid <= (wcnt_n == WU_SAT) &&
                         (state_n != S_FLT);
      // SUSPECT keeps the outputs, i.e. the last plausible pair.
      unique case (state_n)
        S_OK: begin
          bus.w10mm <= filt_n[0];
          bus.w20mm <= filt_n[1];
        end
        S_FLT: begin
          bus.w10mm <= 1'b1;
          bus.w20mm <= 1'b1;
        end
        default: begin
          bus.w10mm <= bus.w10mm;
          bus.w20mm <= bus.w20mm;
        end
      endcase
    end
  end

endmodule
